// File: rtl/stmt_sidefx_pkg.sv
// Shared types and constants for the side-effect event queue.
// The kind enum, sequence/overflow widths and the drain FSM states live here.
package stmt_sidefx_pkg;

    localparam int SEQ_W = 8;
    localparam int OVF_W = 8;

    typedef enum logic [1:0] {
        KIND_DISPLAY  = 2'd0,
        KIND_DPI_CALL = 2'd1,
        KIND_DPI_RET  = 2'd2,
        KIND_RSVD     = 2'd3
    } event_kind_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (v == '1) ? v : v + OVF_W'(1);
    endfunction

endpackage

// File: rtl/stmt_sidefx_fifo.sv
// Event storage with a registered head word: the head register always holds
// the oldest entry, so a word written into an empty queue shows up one cycle later.
module stmt_sidefx_fifo
    import stmt_sidefx_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 42,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] after_pop;
    logic [WIDTH-1:0] head_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok   = push && (count_reg != DEPTH_CNT);
    assign pop_ok    = pop && (count_reg != '0);
    assign rd_next   = pop_ok ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    assign after_pop = count_reg - (pop_ok ? CNT_W'(1) : CNT_W'(0));

    // Storage array has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            rd_ptr_reg <= rd_next;
            count_reg  <= after_pop + (push_ok ? CNT_W'(1) : CNT_W'(0));
            // When the queue would otherwise be empty the incoming word
            // bypasses the array; otherwise the next-oldest stored word loads.
            if (after_pop == '0) begin
                if (push_ok) begin
                    head_reg <= push_data;
                end
            end else if (pop_ok) begin
                head_reg <= mem[rd_next];
            end
        end
    end

    assign head_data = head_reg;
    assign count     = count_reg;

endmodule

// File: rtl/stmt_sidefx_queue.sv
// Side-effect event queue: stamps accepted events with a sequence number,
// counts refused offers, and supports a drain-and-block flush.
module stmt_sidefx_queue
    import stmt_sidefx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ARG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [ARG_W-1:0] in_arg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_kind,
    output logic [ARG_W-1:0] out_arg,
    output logic [SEQ_W-1:0] out_seq,
    input  logic             flush_req,
    output logic             flush_done,
    output logic [OVF_W-1:0] ovf_count
);

    // DEPTH must be a power of two between 2 and 16; pointers wrap by overflow.
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = 2 + SEQ_W + ARG_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    drain_state_e     state_reg;
    drain_state_e     state_next;
    logic             in_ready_reg;
    logic [SEQ_W-1:0] seq_reg;
    logic [OVF_W-1:0] ovf_reg;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] push_data;
    logic             push;
    logic             pop;

    assign push      = in_valid && in_ready_reg;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != '0);
    assign push_data = {in_kind, seq_reg, in_arg};

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:   if (flush_req) state_next = ST_DRAIN;
            ST_DRAIN: if (count_next == '0) state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // Pulses in the cycle whose pop empties the queue (or at once if already empty).
    assign flush_done = (state_reg == ST_DRAIN) && (count_next == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_RUN;
            in_ready_reg <= 1'b0;
            seq_reg      <= '0;
            ovf_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            // Registered from next-cycle occupancy so in_ready never sees out_ready combinationally.
            in_ready_reg <= (state_next == ST_RUN) && (count_next < DEPTH_CNT);
            if (push) begin
                seq_reg <= seq_reg + SEQ_W'(1);
            end
            if (in_valid && !in_ready_reg) begin
                ovf_reg <= sat_inc(ovf_reg);
            end
        end
    end

    stmt_sidefx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    assign in_ready  = in_ready_reg;
    assign out_kind  = head[ENT_W-1 -: 2];
    assign out_seq   = head[ARG_W +: SEQ_W];
    assign out_arg   = head[ARG_W-1:0];
    assign ovf_count = ovf_reg;

endmodule

// File: tb/tb_stmt_sidefx_queue.sv
// Bench for stmt_sidefx_queue: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_stmt_sidefx_queue;

    localparam int DEPTH = 4;
    localparam int ARG_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_kind;
    logic [ARG_W-1:0] in_arg;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_kind;
    logic [ARG_W-1:0] out_arg;
    logic [7:0]       out_seq;
    logic             flush_req;
    logic             flush_done;
    logic [7:0]       ovf_count;

    always #5 clk = ~clk;

    stmt_sidefx_queue #(.DEPTH(DEPTH), .ARG_W(ARG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_arg     (in_arg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kind   (out_kind),
        .out_arg    (out_arg),
        .out_seq    (out_seq),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .ovf_count  (ovf_count)
    );

    typedef struct {
        logic [1:0]       kind;
        logic [ARG_W-1:0] arg;
        logic [7:0]       seq;
    } ent_t;

    ent_t mq[$];
    int   m_seq;
    int   m_ovf;
    bit   m_drain;
    bit   m_rdy;
    int   n_cmp;
    int   n_fail;

    // Expected flush_done for the current cycle given the driven out_ready.
    function automatic bit exp_done();
        int left = mq.size();
        if (left != 0 && out_ready) left--;
        return m_drain && (left == 0);
    endfunction

    // Advance one clock and update the model from the inputs in force.
    task automatic tick();
        bit push = in_valid && m_rdy;
        bit pop  = (mq.size() != 0) && out_ready;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back('{kind: in_kind, arg: in_arg, seq: 8'(m_seq)});
            m_seq = (m_seq + 1) % 256;
        end
        if (in_valid && !m_rdy && m_ovf < 255) m_ovf++;
        if (m_drain) begin
            if (mq.size() == 0) m_drain = 0;
        end else if (flush_req) begin
            m_drain = 1;
        end
        m_rdy = !m_drain && (mq.size() < DEPTH);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; out_ready = 0; flush_req = 0; in_kind = 0; in_arg = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        mq.delete(); m_seq = 0; m_ovf = 0; m_drain = 0; m_rdy = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        in_valid = 1; out_ready = 1; flush_req = 1; in_kind = 3; in_arg = 32'hdead_beef;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done got=%0b exp=0", flush_done); end
        n_cmp++; if ({out_kind, out_arg, out_seq} !== '0) begin n_fail++; $display("FAIL reset_out_fields got=%0h/%0h/%0h exp=0", out_kind, out_arg, out_seq); end
        n_cmp++; if (ovf_count !== 8'd0) begin n_fail++; $display("FAIL reset_ovf got=%0d exp=0", ovf_count); end
        idle_inputs();
        mq.delete(); m_seq = 0; m_ovf = 0; m_drain = 0; m_rdy = 0;
        rst = 0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready got=%0b exp=0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL first_cycle_in_ready got=%0b exp=1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_order();
        out_ready = 0;
        in_valid = 1; in_kind = 2'd0; in_arg = 32'h11; tick();
        in_kind = 2'd1; in_arg = 32'h22; tick();
        in_valid = 0; #1;
        n_cmp++; if (out_valid !== 1'b1 || out_kind !== 2'd0 || out_arg !== 32'h11 || out_seq !== 8'd0) begin
            n_fail++; $display("FAIL order_first got=%0b/%0d/%0h/%0d exp=1/0/11/0", out_valid, out_kind, out_arg, out_seq); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL order_in_ready got=%0b exp=1", in_ready); end
        out_ready = 1; tick();
        n_cmp++; if (out_valid !== 1'b1 || out_kind !== 2'd1 || out_arg !== 32'h22 || out_seq !== 8'd1) begin
            n_fail++; $display("FAIL order_second got=%0b/%0d/%0h/%0d exp=1/1/22/1", out_valid, out_kind, out_arg, out_seq); end
        tick(); out_ready = 0; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty got=%0b exp=0", out_valid); end
        $display("test_order done");
    endtask

    task automatic test_overflow();
        out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_kind = 2'($urandom_range(0, 3)); in_arg = $urandom; #1;
            n_cmp++; if (in_ready !== (i < 4)) begin n_fail++; $display("FAIL ovf_in_ready[%0d] got=%0b exp=%0b", i, in_ready, (i < 4)); end
            tick();
        end
        in_valid = 0; #1;
        n_cmp++; if (ovf_count !== 8'd2) begin n_fail++; $display("FAIL ovf_count got=%0d exp=2", ovf_count); end
        n_cmp++; if (out_seq !== 8'd2 || out_arg !== mq[0].arg) begin n_fail++; $display("FAIL ovf_head got=%0d/%0h exp=2/%0h", out_seq, out_arg, mq[0].arg); end
        $display("test_overflow done");
    endtask

    task automatic test_full_push_pop();
        in_valid = 1; in_arg = 32'hf00d; out_ready = 1; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
        tick();
        in_valid = 0; out_ready = 0; #1;
        n_cmp++; if (out_seq !== 8'd3 || in_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop got=%0d/%0b exp=3/1", out_seq, in_ready); end
        n_cmp++; if (ovf_count !== 8'd3) begin n_fail++; $display("FAIL full_ovf got=%0d exp=3", ovf_count); end
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_seq !== mq[0].seq) begin n_fail++; $display("FAIL full_drain[%0d] got=%0b/%0d exp=1/%0d", k, out_valid, out_seq, mq[0].seq); end
            tick();
        end
        out_ready = 0;
        $display("test_full_push_pop done");
    endtask

    task automatic test_flush();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin in_valid = 1; in_arg = $urandom; tick(); end
        in_valid = 0; flush_req = 1; #1;
        n_cmp++; if (in_ready !== 1'b1 || flush_done !== 1'b0) begin n_fail++; $display("FAIL flush_issue got=%0b/%0b exp=1/0", in_ready, flush_done); end
        tick();
        flush_req = 0; out_ready = 1; in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_in_ready[%0d] got=%0b exp=0", k, in_ready); end
            n_cmp++; if (flush_done !== (k == 2) || flush_done !== exp_done()) begin n_fail++; $display("FAIL drain_done[%0d] got=%0b exp=%0b", k, flush_done, (k == 2)); end
            tick();
        end
        in_valid = 0; #1;
        n_cmp++; if (in_ready !== 1'b1 || flush_done !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_back_to_run got=%0b/%0b/%0b exp=1/0/0", in_ready, flush_done, out_valid); end
        n_cmp++; if (ovf_count !== 8'(m_ovf)) begin n_fail++; $display("FAIL flush_ovf got=%0d exp=%0d", ovf_count, m_ovf); end
        out_ready = 0;
        $display("test_flush done");
    endtask

    task automatic test_empty_flush();
        flush_req = 1; #1;
        n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL eflush_early got=%0b exp=0", flush_done); end
        tick();
        flush_req = 0; #1;
        n_cmp++; if (flush_done !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL eflush_done got=%0b/%0b exp=1/0", flush_done, in_ready); end
        tick();
        n_cmp++; if (flush_done !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL eflush_after got=%0b/%0b exp=0/1", flush_done, in_ready); end
        // an offer in the flush cycle is still stored and must drain
        in_valid = 1; flush_req = 1; in_kind = 2'd3; in_arg = 32'h5a5a; tick();
        in_valid = 0; flush_req = 0; #1;
        n_cmp++; if (out_valid !== 1'b1 || out_kind !== 2'd3 || out_arg !== 32'h5a5a || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_accept got=%0b/%0d/%0h/%0b exp=1/3/5a5a/0", out_valid, out_kind, out_arg, in_ready); end
        out_ready = 1; #1;
        n_cmp++; if (flush_done !== 1'b1) begin n_fail++; $display("FAIL flush_accept_done got=%0b exp=1", flush_done); end
        tick(); out_ready = 0;
        $display("test_empty_flush done");
    endtask

    task automatic test_seq_wrap();
        int  pops = 0;
        bit  saw_wrap = 0;
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 301; i++) begin
            in_valid = (i < 300); in_arg = $urandom; in_kind = 2'($urandom_range(0, 3)); #1;
            if (out_valid) begin
                n_cmp++; if (out_seq !== 8'(pops % 256) || out_arg !== mq[0].arg) begin
                    n_fail++; $display("FAIL wrap_seq[%0d] got=%0d/%0h exp=%0d/%0h", pops, out_seq, out_arg, pops % 256, mq[0].arg); end
                if (pops == 256 && out_seq === 8'd0) saw_wrap = 1;
                pops++;
            end
            tick();
        end
        n_cmp++; if (saw_wrap !== 1'b1 || pops !== 300) begin n_fail++; $display("FAIL wrap_seen got=%0b/%0d exp=1/300", saw_wrap, pops); end
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 304; i++) tick();
        in_valid = 0; #1;
        n_cmp++; if (ovf_count !== 8'd255 || ovf_count !== 8'(m_ovf)) begin n_fail++; $display("FAIL ovf_saturate got=%0d exp=255", ovf_count); end
        tick();
        n_cmp++; if (ovf_count !== 8'd255) begin n_fail++; $display("FAIL ovf_hold got=%0d exp=255", ovf_count); end
        $display("test_seq_wrap done");
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin in_valid = 1; in_arg = $urandom; tick(); end
        in_valid = 0; flush_req = 1; tick();
        flush_req = 0; out_ready = 1; tick(); tick();
        rst = 1; #1;
        n_cmp++; if (out_valid !== 1'b0 || flush_done !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_drain got=%0b/%0b/%0b exp=0/0/0", out_valid, flush_done, in_ready); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL rst_drain_pulse[%0d] got=%0b exp=0", i, flush_done); end
        end
        idle_inputs();
        mq.delete(); m_seq = 0; m_ovf = 0; m_drain = 0; m_rdy = 0;
        rst = 0; tick();
        in_valid = 1; in_arg = 32'h77; tick();
        in_valid = 0; #1;
        n_cmp++; if (out_valid !== 1'b1 || out_seq !== 8'd0 || out_arg !== 32'h77) begin
            n_fail++; $display("FAIL rst_first_seq got=%0b/%0d/%0h exp=1/0/77", out_valid, out_seq, out_arg); end
        $display("test_reset_mid_drain done");
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1);
            flush_req = ($urandom_range(0, 24) == 0);
            in_kind   = 2'($urandom_range(0, 3));
            in_arg    = $urandom;
            #1;
            n_cmp++; if (out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", c, out_valid, (mq.size() != 0)); end
            if (mq.size() != 0) begin
                n_cmp++; if (out_kind !== mq[0].kind || out_arg !== mq[0].arg || out_seq !== mq[0].seq) begin
                    n_fail++; $display("FAIL rnd_head[%0d] got=%0d/%0h/%0d exp=%0d/%0h/%0d", c, out_kind, out_arg, out_seq, mq[0].kind, mq[0].arg, mq[0].seq); end
            end
            n_cmp++; if (in_ready !== m_rdy) begin n_fail++; $display("FAIL rnd_in_ready[%0d] got=%0b exp=%0b", c, in_ready, m_rdy); end
            n_cmp++; if (flush_done !== exp_done()) begin n_fail++; $display("FAIL rnd_flush_done[%0d] got=%0b exp=%0b", c, flush_done, exp_done()); end
            n_cmp++; if (ovf_count !== 8'(m_ovf)) begin n_fail++; $display("FAIL rnd_ovf[%0d] got=%0d exp=%0d", c, ovf_count, m_ovf); end
            tick();
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        idle_inputs();
        test_reset();
        test_order();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_empty_flush();
        test_seq_wrap();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
